uart_receiver: RTL
==================

# uart_receiver

Byte-oriented UART receiver (8 data bits, no parity, 1 stop bit, LSB first) for the SoC's `uart_rx` pin, complementing the existing transmit path. It synchronises the asynchronous serial line, recovers bytes by mid-bit sampling with a fixed clock-per-bit divider, and presents each byte through a valid/ready holding register to the CPU/peripheral side. Framing errors and overruns are flagged as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 868, clk cycles per serial bit (100 MHz / 115200); legal range ≥ 4.
- `HALF_BIT`, `CLKS_PER_BIT/2` (integer division), start-bit mid-point offset; derived, not overridden.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, asynchronous, idle high.
- `rx_data`  out  8  received byte (holding register).
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `rx_ready`  in  1  consumer accepts the byte when `rx_valid && rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: byte completed while the holding register was still full.

## Operation
- `rx` passes through a 2-flop synchroniser (both flops reset to 1) to give `rx_s`. All FSM decisions use `rx_s`.
- The FSM has five states and uses a bit-period counter `cnt` plus a 3-bit `bit_idx`.
  - IDLE: when `rx_s==0`, go to START with `cnt=0`.
  - START: increment `cnt`. At `cnt==HALF_BIT-1`, sample `rx_s`.
    - If 0, go to DATA with `cnt=0` and `bit_idx=0`.
    - If 1, treat it as a glitch and go to IDLE. No outputs change.
  - DATA: increment `cnt`. At `cnt==CLKS_PER_BIT-1`, sample `rx_s` into shift bit `bit_idx` (LSB first), clear `cnt`, and increment `bit_idx`. After bit 7 is sampled, go to STOP.
  - STOP: at `cnt==CLKS_PER_BIT-1`, sample `rx_s`.
    - If 1 (good frame), deliver the byte (see below) and go to IDLE.
    - If 0, pulse `frame_err`, discard the byte, and go to BREAK.
  - BREAK: wait for `rx_s==1`, then go to IDLE. A held-low line produces exactly one `frame_err`.
- The FSM returns to IDLE at the stop-bit mid-point, so a following start edge is detected without loss.
- Delivery on a good frame:
  - If `rx_valid==0`, or the handshake `rx_valid && rx_ready` occurs in the same cycle: load `rx_data` and set `rx_valid=1`.
  - Otherwise: pulse `overrun`, drop the new byte, and keep the old `rx_data`/`rx_valid`.
- Handshake: `rx_valid` stays high until accepted. On acceptance it clears next cycle, unless a new byte loads in the same cycle, in which case it stays high.
- `rx_data` does not change while `rx_valid==1` except in the simultaneous accept+load case.
- Reset, asynchronous and valid at any time including mid-frame, forces:
  - state IDLE, `cnt=0`, `bit_idx=0`, shift register 0;
  - `rx_data=0`, `rx_valid=0`, `frame_err=0`, `overrun=0`;
  - synchroniser flops to 1.

## Timing
- All outputs are registered. `frame_err` and `overrun` are exactly one cycle wide.
- Synchroniser latency is 2 cycles.
- Start-bit acceptance occurs `HALF_BIT` cycles after START is entered.
- Data bit k is sampled `HALF_BIT + (k+1)*CLKS_PER_BIT` cycles after START entry.
- `rx_valid` rises one cycle after the stop-bit sample. Nominal: 3 + `HALF_BIT` + 9×`CLKS_PER_BIT` cycles after the first clk edge seeing `rx` low. Benches allow ±1 cycle.
- Receiver tolerance is about ±4 % baud mismatch, since sampling is mid-bit with no resync inside the frame.
- Back-to-back frames with zero idle time between stop and next start are received without loss.

## Structure
- Shared package `uart_pkg` holds:
  - the receiver state encoding (IDLE, START, DATA, STOP, BREAK);
  - the frame constants (8 data bits, 1 stop bit);
  - the default baud divider, shared with the transmitter so both ends use the same `CLKS_PER_BIT`.
- One sub-module is natural: `sync_2ff`, a 1-bit two-flop synchroniser with reset value parameter. It is reusable for the `sw` GPIO inputs.
- Everything else stays in `uart_receiver`.

## Test plan
All scenarios use `CLKS_PER_BIT=16` and an ideal bit-period driver.
1. Send 0x55 with `rx_ready=1`: one-cycle `rx_valid` with `rx_data=0x55`; `frame_err` and `overrun` stay 0.
2. Send 0xA3 with `rx_ready=0`, then 0x3C: `overrun` pulses once at the 0x3C stop sample and `rx_data` stays 0xA3. Raising `rx_ready` clears `rx_valid` the next cycle.
3. Drive `rx` low for 5 cycles, then high: no `rx_valid`, no `frame_err`, and the FSM is back in IDLE.
4. Send 0x0F with the stop bit driven 0 and the line held low for 40 cycles, then high; then send 0x81:
   - exactly one `frame_err` pulse and no `rx_valid` for the first frame;
   - 0x81 is received correctly.
5. Assert `rst_n` low during data bit 3 of 0x6E: all outputs go to 0 immediately. After release, a following 0xC7 is received correctly and 0x6E is never delivered.
6. Send 0x00 then 0xFF back-to-back with no idle gap and `rx_ready=1`: two deliveries, 0x00 then 0xFF, with no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and receiver state encoding
package uart_pkg;

   localparam int UART_DATA_BITS    = 8;
   localparam int UART_STOP_BITS    = 1;
   // Shared with the transmitter so both ends of the link agree on the baud divider.
   localparam int UART_CLKS_PER_BIT = 868;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchroniser with selectable reset value
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling and valid/ready holding register
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CNT_W    = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

   rx_state_t                 state;
   logic [CNT_W-1:0]          cnt;
   logic [2:0]                bit_idx;
   logic [UART_DATA_BITS-1:0] shift;
   logic                      rx_s;
   logic                      accept;

   sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   assign accept = rx_valid && rx_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RX_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (accept) begin
            rx_valid <= 1'b0;
         end

         case (state)
            RX_IDLE: begin
               cnt <= '0;
               if (!rx_s) begin
                  state <= RX_START;
               end
            end

            RX_START: begin
               if (cnt == CNT_HALF) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  // A start bit that is high again at its mid-point was only a glitch.
                  state   <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            RX_DATA: begin
               if (cnt == CNT_FULL) begin
                  cnt            <= '0;
                  shift[bit_idx] <= rx_s;
                  bit_idx        <= bit_idx + 1'b1;
                  if (bit_idx == LAST_BIT) begin
                     state <= RX_STOP;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            RX_STOP: begin
               if (cnt == CNT_FULL) begin
                  cnt <= '0;
                  if (rx_s) begin
                     // Load wins over the accept-clear above when both happen together.
                     if (!rx_valid || accept) begin
                        rx_data  <= shift;
                        rx_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                     state <= RX_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= RX_BREAK;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            RX_BREAK: begin
               cnt <= '0;
               if (rx_s) begin
                  state <= RX_IDLE;
               end
            end

            default: begin
               state <= RX_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
